// File: rtl/frac_ce_pkg.sv
// frac_ce_pkg: shared types and helpers for the fractional clock-enable generator.
// Rate values are ACC_W_DEF bits wide throughout.
package frac_ce_pkg;

  localparam int unsigned ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    L_IDLE,
    L_ARMED,
    L_VALID
  } lock_e;

  function automatic logic [ACC_W_DEF-1:0] clamp_rate(
    input logic [ACC_W_DEF-1:0] value,
    input logic [ACC_W_DEF-1:0] lo,
    input logic [ACC_W_DEF-1:0] hi
  );
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  function automatic logic [ACC_W_DEF-1:0] sat_mul(
    input logic [ACC_W_DEF-1:0] count,
    input logic [ACC_W_DEF-1:0] k
  );
    logic [2*ACC_W_DEF-1:0] p;
    p = {{ACC_W_DEF{1'b0}}, count}
      * {{ACC_W_DEF{1'b0}}, k};
    if (|p[2*ACC_W_DEF-1:ACC_W_DEF])
      return '1;
    return p[ACC_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/frac_ce_if.sv
// frac_ce_if: per-channel rate requests, lock controls and enable outputs.
// The master drives requests; the generator is the slave.
interface frac_ce_if
  import frac_ce_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ACC_W    = ACC_W_DEF
);
  logic [CHANNELS*ACC_W-1:0] rate_i;
  logic [CHANNELS-1:0]       lock_en_i;
  logic [CHANNELS-1:0]       sync_i;
  logic [CHANNELS-1:0]       ce_o;
  logic [CHANNELS*ACC_W-1:0] rate_o;
  logic [CHANNELS-1:0]       rate_chg_o;

  modport master (
    output rate_i, lock_en_i, sync_i,
    input  ce_o, rate_o, rate_chg_o
  );

  modport slave (
    input  rate_i, lock_en_i, sync_i,
    output ce_o, rate_o, rate_chg_o
  );
endinterface

// File: rtl/frac_ce_chan.sv
// frac_ce_chan: one phase-accumulator enable channel with optional
// frame-sync lock that retunes the rate from enables counted per frame.
module frac_ce_chan
  import frac_ce_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 42000000,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned TARGET_FPS = 60,
  parameter int unsigned MIN_HZ     = 5000000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [ACC_W-1:0] rate_i,
  input  logic             lock_en_i,
  input  logic             sync_i,
  output logic             ce_o,
  output logic [ACC_W-1:0] rate_o,
  output logic             rate_chg_o
);

  localparam logic [ACC_W-1:0] CLK_W = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] MIN_W = ACC_W'(MIN_HZ);
  localparam logic [ACC_W-1:0] FPS_W = ACC_W'(TARGET_FPS);
  localparam logic [ACC_W:0]   CLK_X = (ACC_W+1)'(CLK_HZ);

  lock_e            st_q, st_d;
  logic             sync_q, sync_edge;
  logic             armed, valid;
  logic [ACC_W-1:0] acc_q, stage1_q, prev_q;
  logic [ACC_W-1:0] pix_q, meas_q, req;
  logic [ACC_W:0]   nxt;

  assign sync_edge = sync_i & ~sync_q;
  assign nxt       = {1'b0, acc_q} + {1'b0, rate_o};
  assign req       = clamp_rate(
    (lock_en_i && valid) ? meas_q : rate_i,
    '0, CLK_W);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) st_q <= L_IDLE;
    else       st_q <= st_d;
  end

  // Disable dominates a coincident sync edge
  always_comb begin
    st_d = st_q;
    unique case (1'b1)
      !lock_en_i:
        st_d = L_IDLE;
      lock_en_i && sync_edge && st_q == L_IDLE:
        st_d = L_ARMED;
      lock_en_i && sync_edge && st_q != L_IDLE:
        st_d = L_VALID;
      default: ;
    endcase
  end

  always_comb begin
    armed = 1'b0;
    valid = 1'b0;
    unique case (st_q)
      L_ARMED: armed = 1'b1;
      L_VALID: begin
        armed = 1'b1;
        valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase is never cleared on a rate change
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      ce_o       <= 1'b0;
      stage1_q   <= '0;
      rate_o     <= '0;
      prev_q     <= '0;
      rate_chg_o <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      sync_q   <= sync_i;
      stage1_q <= req;
      rate_o   <= stage1_q;
      prev_q   <= rate_o;
      if (prev_q != rate_o)
        rate_chg_o <= ~rate_chg_o;
      if (nxt >= CLK_X) begin
        acc_q <= ACC_W'(nxt - CLK_X);
        ce_o  <= 1'b1;
      end else begin
        acc_q <= nxt[ACC_W-1:0];
        ce_o  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pix_q  <= '0;
      meas_q <= '0;
    end else begin
      unique case (1'b1)
        !lock_en_i:
          pix_q <= '0;
        lock_en_i && sync_edge: begin
          pix_q <= ACC_W'(ce_o);
          if (armed)
            meas_q <= clamp_rate(
              sat_mul(pix_q, FPS_W), MIN_W, CLK_W);
        end
        default:
          if (ce_o && pix_q != '1)
            pix_q <= pix_q + ACC_W'(1);
      endcase
    end
  end

endmodule

// File: rtl/frac_ce_gen.sv
// frac_ce_gen: bank of independent fractional clock-enable channels
// for the pixel and audio enable paths.
module frac_ce_gen
  import frac_ce_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 42000000,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned TARGET_FPS = 60,
  parameter int unsigned MIN_HZ     = 5000000
) (
  input logic      clk_sys,
  input logic      reset,
  frac_ce_if.slave bus
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    frac_ce_chan #(
      .CLK_HZ    (CLK_HZ),
      .ACC_W     (ACC_W),
      .TARGET_FPS(TARGET_FPS),
      .MIN_HZ    (MIN_HZ)
    ) u_chan (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .rate_i    (bus.rate_i[n*ACC_W +: ACC_W]),
      .lock_en_i (bus.lock_en_i[n]),
      .sync_i    (bus.sync_i[n]),
      .ce_o      (bus.ce_o[n]),
      .rate_o    (bus.rate_o[n*ACC_W +: ACC_W]),
      .rate_chg_o(bus.rate_chg_o[n])
    );
  end

endmodule

// File: tb/tb_frac_ce_gen.sv
// tb_frac_ce_gen: two generator instances (full-rate and scaled clock) checked
// against a cumulative-phase and per-frame counting reference model.
module tb_frac_ce_gen;

  localparam int NCH = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  frac_ce_if #(.CHANNELS(2), .ACC_W(32)) bus_b ();
  frac_ce_if #(.CHANNELS(2), .ACC_W(32)) bus_s ();

  frac_ce_gen u_big (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus_b)
  );

  frac_ce_gen #(
    .CLK_HZ(42000),
    .MIN_HZ(5000)
  ) u_small (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus_s)
  );

  // channels 0,1: big instance; 2,3: small instance
  longint clk_of[NCH] = '{42000000, 42000000, 42000, 42000};
  longint min_of[NCH] = '{5000000, 5000000, 5000, 5000};

  longint rate[NCH];
  bit     lock[NCH];
  bit     sync[NCH];
  int     per[NCH];
  int     tick;

  // reference: enables = floor(total phase added / CLK_HZ)
  longint m_sum[NCH], m_st1[NCH], m_ro[NCH], m_prev[NCH];
  longint m_pix[NCH], m_meas[NCH];
  bit     m_ce[NCH], m_chg[NCH], m_sq[NCH];
  bit     m_armed[NCH], m_valid[NCH];

  int mism[NCH];
  int cnt_dut[NCH];
  int errors = 0;
  int checks = 0;
  int base;

  function automatic bit dut_ce(input int i);
    if (i < 2) return bus_b.ce_o[i];
    return bus_s.ce_o[i-2];
  endfunction

  function automatic logic [31:0] dut_ro(input int i);
    if (i < 2) return bus_b.rate_o[i*32 +: 32];
    return bus_s.rate_o[(i-2)*32 +: 32];
  endfunction

  function automatic bit dut_chg(input int i);
    if (i < 2) return bus_b.rate_chg_o[i];
    return bus_s.rate_chg_o[i-2];
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      bus_b.rate_i[i*32 +: 32] = 32'(rate[i]);
      bus_b.lock_en_i[i]       = lock[i];
      bus_b.sync_i[i]          = sync[i];
      bus_s.rate_i[i*32 +: 32] = 32'(rate[i+2]);
      bus_s.lock_en_i[i]       = lock[i+2];
      bus_s.sync_i[i]          = sync[i+2];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sum[i] = 0; m_st1[i] = 0; m_ro[i] = 0;
      m_prev[i] = 0; m_pix[i] = 0; m_meas[i] = 0;
      m_ce[i] = 0; m_chg[i] = 0; m_sq[i] = 0;
      m_armed[i] = 0; m_valid[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit     e;
      bit     c;
      longint q;
      longint m;
      e = sync[i] && !m_sq[i];
      q = (lock[i] && m_valid[i]) ? m_meas[i] : rate[i];
      if (q > clk_of[i]) q = clk_of[i];
      c = ((m_sum[i] + m_ro[i]) / clk_of[i])
          != (m_sum[i] / clk_of[i]);
      if (!lock[i]) begin
        m_armed[i] = 0;
        m_valid[i] = 0;
        m_pix[i]   = 0;
      end else if (e) begin
        if (m_armed[i]) begin
          m = m_pix[i] * 60;
          if (m > 64'd4294967295) m = 64'd4294967295;
          if (m < min_of[i]) m = min_of[i];
          if (m > clk_of[i]) m = clk_of[i];
          m_meas[i]  = m;
          m_valid[i] = 1;
        end
        m_armed[i] = 1;
        m_pix[i]   = m_ce[i] ? 1 : 0;
      end else if (m_ce[i] && m_pix[i] < 64'd4294967295) begin
        m_pix[i]++;
      end
      if (m_prev[i] != m_ro[i]) m_chg[i] = !m_chg[i];
      m_prev[i] = m_ro[i];
      m_sum[i] += m_ro[i];
      m_ro[i]   = m_st1[i];
      m_st1[i]  = q;
      m_sq[i]   = sync[i];
      m_ce[i]   = c;
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NCH; i++) begin
      if (dut_ce(i) !== m_ce[i] ||
          dut_ro(i) !== 32'(m_ro[i]) ||
          dut_chg(i) !== m_chg[i])
        mism[i]++;
      cnt_dut[i] += int'(dut_ce(i));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NCH; i++)
        sync[i] = per[i] != 0 && (tick % per[i]) == per[i] - 1;
      drive();
      @(posedge clk_sys);
      model_step();
      @(negedge clk_sys);
      compare();
      tick++;
    end
  endtask

  task automatic chk_mism(input string tag);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("%s_mism%0d", tag, i), 64'(mism[i]), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      rate[i] = 0; lock[i] = 0; sync[i] = 0; per[i] = 0;
      mism[i] = 0; cnt_dut[i] = 0;
    end
    model_reset();
    drive();
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("rst_ce%0d", i), 64'(dut_ce(i)), 0);
      chk($sformatf("rst_ro%0d", i), 64'(dut_ro(i)), 0);
      chk($sformatf("rst_chg%0d", i), 64'(dut_chg(i)), 0);
    end

    rate[0] = 8000000;
    rate[1] = 42000000;
    rate[2] = 8000; lock[2] = 1; per[2] = 525;
    rate[3] = 8000; lock[3] = 1; per[3] = 42;
    tick = 0;
    drive();
    reset = 1'b0;
    run(2);
    chk("ro_latency", 64'(dut_ro(0)), 8000000);

    base = cnt_dut[1];
    run(1100);
    // 100 enables in the first measured frame -> 6000
    chk("lock_first_frame", 64'(dut_ro(2)), 6000);
    run(8900);
    chk("full_rate_cnt", 64'(cnt_dut[1] - base), 10000);
    chk("lock_min_clamp", 64'(dut_ro(3)), 5000);
    chk_mism("seg1");

    rate[1] = 0;
    run(2);
    base = cnt_dut[1];
    run(10000);
    chk("zero_rate_cnt", 64'(cnt_dut[1] - base), 0);
    chk("chg_once", 64'(dut_chg(0)), 1);
    run(996);

    rate[0] = 24000000;
    run(21000);
    // 21000 adds of 8M and 20998 of 24M over 42M
    chk("switch_total", 64'(cnt_dut[0]), 15998);
    chk("switch_ro", 64'(dut_ro(0)), 24000000);
    chk("chg_twice", 64'(dut_chg(0)), 0);
    chk("lock_settled", 64'(dut_ro(2)), 5000);
    chk_mism("seg2");

    lock[2] = 0; rate[2] = 9000;
    run(2);
    chk("lock_drop", 64'(dut_ro(2)), 9000);
    lock[2] = 1;

    for (int it = 0; it < 4; it++) begin
      rate[0] = $urandom_range(0, 48000000);
      rate[1] = $urandom_range(0, 48000000);
      rate[2] = $urandom_range(0, 48000);
      rate[3] = $urandom_range(0, 48000);
      lock[0] = 1'($urandom_range(0, 1));
      lock[3] = 1'($urandom_range(0, 1));
      per[0]  = $urandom_range(0, 3000);
      per[3]  = $urandom_range(20, 600);
      run($urandom_range(300, 1500));
      chk_mism($sformatf("rnd%0d", it));
    end

    lock[0] = 0; per[0] = 0;
    lock[2] = 1; rate[2] = 8000; per[2] = 525;
    rate[1] = 21000000;
    run(800);
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("midrst_ce%0d", i), 64'(dut_ce(i)), 0);
      chk($sformatf("midrst_ro%0d", i), 64'(dut_ro(i)), 0);
    end
    repeat (3) @(negedge clk_sys);
    rate[0] = $urandom_range(1, 42000000);
    tick = 0;
    drive();
    reset = 1'b0;
    base = cnt_dut[1];
    run(600);
    chk("post_rst_one_sync", 64'(dut_ro(2)), 8000);
    rate[0] = $urandom_range(0, 42000000);
    run(600);
    chk("post_rst_two_sync", 64'(dut_ro(2)), 6000);
    // ch1 at 21M: 1198 adds after the two-cycle pipeline
    chk("ch1_indep_cnt", 64'(cnt_dut[1] - base), 599);
    chk_mism("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
